// File: rtl/lsu_writeback.sv
// Single-outstanding load/store unit: bus request, load align/extend, one-cycle RF write, done/err pulse.
// Latency accept->done is 5 cycles for loads and 4 for stores on a zero-wait bus; bus stalls simply hold REQ/WAIT.
module lsu_writeback #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_is_store_i,
  input  logic [2:0]                req_funct3_i,
  input  logic [XLEN-1:0]           req_addr_i,
  input  logic [XLEN-1:0]           req_wdata_i,
  input  logic [REG_ADDR_WIDTH-1:0] req_rd_i,
  output logic                      mem_req_valid_o,
  input  logic                      mem_req_ready_i,
  output logic                      mem_req_wen_o,
  output logic [XLEN-1:0]           mem_req_addr_o,
  output logic [XLEN-1:0]           mem_req_wdata_o,
  output logic [3:0]                mem_req_wstrb_o,
  input  logic                      mem_resp_valid_i,
  input  logic [XLEN-1:0]           mem_resp_rdata_i,
  input  logic                      mem_resp_err_i,
  output logic                      rf_wen_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [XLEN-1:0]           rf_wdata_o,
  output logic                      done_o,
  output logic                      err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WB,
    S_FIN
  } state_t;

  state_t                    state_q, state_d;
  logic                      ready_q, ready_d;
  logic                      is_store_q, is_store_d;
  logic [2:0]                funct3_q, funct3_d;
  logic [1:0]                lane_q, lane_d;
  logic [XLEN-1:0]           addr_q, addr_d;
  logic [XLEN-1:0]           wdata_q, wdata_d;
  logic [3:0]                wstrb_q, wstrb_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                      err_q, err_d;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]           rf_wdata_q, rf_wdata_d;

  logic                      req_legal;
  logic                      req_misaligned;
  logic                      req_f3_ok;
  logic [XLEN-1:0]           st_wdata;
  logic [3:0]                st_wstrb;
  logic [7:0]                ld_byte;
  logic [15:0]               ld_half;
  logic                      ld_sext;
  logic [XLEN-1:0]           ld_ext;

  // Legality and store lane formatting are evaluated on the raw request so they can be latched at accept.
  always_comb begin
    req_f3_ok = 1'b0;
    if (req_is_store_i) begin
      req_f3_ok = !req_funct3_i[2] && (req_funct3_i[1:0] != 2'b11);
    end else begin
      case (req_funct3_i)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_f3_ok = 1'b1;
        default:                                req_f3_ok = 1'b0;
      endcase
    end
    req_misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                     ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
    req_legal = req_f3_ok && !req_misaligned;

    st_wdata = '0;
    st_wstrb = 4'b0000;
    if (req_is_store_i) begin
      case (req_funct3_i[1:0])
        2'b00: begin
          st_wdata = {(XLEN/8){req_wdata_i[7:0]}};
          st_wstrb = 4'b0001 << req_addr_i[1:0];
        end
        2'b01: begin
          st_wdata = {(XLEN/16){req_wdata_i[15:0]}};
          st_wstrb = 4'b0011 << req_addr_i[1:0];
        end
        default: begin
          st_wdata = req_wdata_i;
          st_wstrb = 4'b1111;
        end
      endcase
    end
  end

  // Load extraction from the returned word using the latched byte lane.
  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = mem_resp_rdata_i[7:0];
      2'd1:    ld_byte = mem_resp_rdata_i[15:8];
      2'd2:    ld_byte = mem_resp_rdata_i[23:16];
      default: ld_byte = mem_resp_rdata_i[31:24];
    endcase
    ld_half = lane_q[1] ? mem_resp_rdata_i[31:16] : mem_resp_rdata_i[15:0];
    ld_sext = !funct3_q[2];
    case (funct3_q[1:0])
      2'b00:   ld_ext = {{(XLEN-8){ld_sext & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{(XLEN-16){ld_sext & ld_half[15]}}, ld_half};
      default: ld_ext = mem_resp_rdata_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    lane_d     = lane_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rd_d       = rd_q;
    err_d      = err_q;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i && ready_q) begin
          is_store_d = req_is_store_i;
          funct3_d   = req_funct3_i;
          lane_d     = req_addr_i[1:0];
          addr_d     = {req_addr_i[XLEN-1:2], 2'b00};
          wdata_d    = st_wdata;
          wstrb_d    = st_wstrb;
          rd_d       = req_rd_i;
          err_d      = !req_legal;
          state_d    = req_legal ? S_REQ : S_FIN;
        end
      end
      S_REQ: begin
        if (mem_req_ready_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid_i) begin
          if (mem_resp_err_i) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else if (is_store_q) begin
            state_d = S_FIN;
          end else begin
            rf_waddr_d = rd_q;
            rf_wdata_d = ld_ext;
            state_d    = S_WB;
          end
        end
      end
      S_WB:    state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Ready is registered so it reads 0 while reset is held and rises once the block is idle.
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      lane_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= 4'b0000;
      rd_q       <= '0;
      err_q      <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      lane_q     <= lane_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign req_ready_o     = ready_q;
  assign mem_req_valid_o = (state_q == S_REQ);
  assign mem_req_wen_o   = is_store_q;
  assign mem_req_addr_o  = addr_q;
  assign mem_req_wdata_o = wdata_q;
  assign mem_req_wstrb_o = wstrb_q;
  assign rf_wen_o        = (state_q == S_WB) && (rd_q != '0);
  assign rf_waddr_o      = rf_waddr_q;
  assign rf_wdata_o      = rf_wdata_q;
  assign done_o          = (state_q == S_FIN);
  assign err_o           = (state_q == S_FIN) && err_q;

endmodule

// File: doc/lsu_writeback.md
Name: lsu_writeback

Overview:
- Multi-cycle load/store unit sitting between the execute stage and the register-file write port of the RV32E core.
- Accepts one memory operation at a time and drives it over a valid/ready data bus.
- For loads, aligns and sign/zero-extends the returned word and issues a single-cycle register-file write (wen/waddr/wdata).
- For stores, generates byte strobes and reports completion.

Parameters:
- XLEN, 32, data/address width.
- REG_ADDR_WIDTH, 5, destination register index width. The register file decodes only bits [3:0]; this block passes the full index.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  execute stage presents an operation
- req_ready_o  out  1  block can accept (high only in IDLE)
- req_is_store_i  in  1  1=store, 0=load
- req_funct3_i  in  3  RISC-V funct3 (size/sign)
- req_addr_i  in  XLEN  effective byte address
- req_wdata_i  in  XLEN  store data (rs2)
- req_rd_i  in  REG_ADDR_WIDTH  load destination register
- mem_req_valid_o  out  1  bus request valid
- mem_req_ready_i  in  1  bus accepts request
- mem_req_wen_o  out  1  1=write
- mem_req_addr_o  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- mem_req_wdata_o  out  XLEN  lane-shifted store data
- mem_req_wstrb_o  out  4  byte strobes (0 for loads)
- mem_resp_valid_i  in  1  response valid (single cycle, always accepted)
- mem_resp_rdata_i  in  XLEN  read word
- mem_resp_err_i  in  1  bus error, qualified by resp_valid
- rf_wen_o  out  1  register-file write enable
- rf_waddr_o  out  REG_ADDR_WIDTH  write index
- rf_wdata_o  out  XLEN  write data
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  valid with done_o: misaligned, illegal funct3 or bus error

Behaviour:
- Reset: all outputs 0, FSM in IDLE. Reset asserted mid-operation aborts it with no rf write and no done. A mem_resp_valid_i arriving in IDLE is ignored.
- FSM states are IDLE, REQ, WAIT, WB, FIN.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch all request fields.
  - Check legality:
    - load funct3 must be in {000,001,010,100,101}; store funct3 in {000,001,010}.
    - Halfword requires addr[0]=0; word requires addr[1:0]=00.
  - Illegal -> FIN with err=1; no bus access.
  - Legal -> REQ.
- REQ:
  - mem_req_valid_o=1, with addr, wen, wdata and wstrb held stable until mem_req_ready_i.
  - Handshake -> WAIT (mem_req_valid_o low next cycle).
  - If ready is already high in the first REQ cycle, the handshake takes exactly one cycle.
- WAIT:
  - On mem_resp_valid_i with err -> FIN, err=1, no rf write.
  - Store -> FIN.
  - Load -> register the extended data, then WB.
- WB: rf_wen_o=1 for exactly one cycle, then FIN. If rd=0, rf_wen_o stays 0, but WB/FIN timing is unchanged.
- FIN: done_o=1 (and err_o as latched) for one cycle, then IDLE.
- Load extraction uses lane = addr[1:0]:
  - LB/LBU: byte at lane, sign-/zero-extended.
  - LH/LHU: halfword at lane[1], extended.
  - LW: whole word.
- Store formatting:
  - SB: wdata = {4{byte}}, wstrb = 0001<<lane.
  - SH: wdata = {2{half}}, wstrb = 0011<<lane.
  - SW: wdata unchanged, wstrb = 1111.
- Minimum latency, accept to done_o with a zero-wait bus (ready high, response the cycle after the handshake):
  - Load: 5 cycles (IDLE, REQ, WAIT, WB, FIN).
  - Store: 4 cycles.
- rf_waddr_o/rf_wdata_o are registered and hold their value outside WB. Only rf_wen_o qualifies them.
- No new request is accepted until the cycle after FIN, so there is never more than one outstanding operation.

Test Plan:
- LW addr 0x8000_0004 rd=5, memory returns 0xDEAD_BEEF -> bus addr 0x8000_0004, wstrb 0000; one cycle of rf_wen=1, waddr=5, wdata=0xDEAD_BEEF; then done_o=1, err_o=0; accept-to-done is 5 cycles.
- LB / LBU at 0x8000_0003, word 0x80FF_0000 -> LB writes 0xFFFF_FF80, LBU writes 0x0000_0080; LH at 0x...02 of 0x8001_xxxx writes 0xFFFF_8001.
- SB at 0x8000_0002 of data 0x1234_5678 -> wdata 0x7878_7878, wstrb 0100, wen=1, no rf_wen, done after response.
- LW at 0x8000_0006 -> no mem_req_valid_o ever; done_o=1 with err_o=1; rf_wen_o stays 0. SW with funct3=011 gives the same result.
- mem_req_ready_i held low 3 cycles then high -> request fields stable all 4 cycles. Load with rd=0 -> no rf_wen. Response with mem_resp_err_i=1 -> err_o=1, no write.
- Assert rst_n low during WAIT, then release and deliver a stale response -> no rf_wen, no done_o; next LW completes normally.
